id_exe_stage: RTL

ID/EXE pipeline register for the 5-stage RV32I core. Sits directly downstream of the forward calculator. It consumes the per-operand forward selects and resolves each operand from three sources: the register file, the EXE-stage ALU result, and the MEM-stage write-back data. It also latches the decoded instruction into EXE and detects load-use hazards, inserting one bubble and stalling IF/ID when a loaded value cannot be forwarded in time.

---
 rtl/id_exe_stage.sv | 126 ++++++++++++
 1 files changed

// File: rtl/id_exe_stage.sv
// ---------------------------------------------------------------------------
// id_exe_stage
//   ID/EXE pipeline register for the 5-stage RV32I core. It resolves both
//   source operands from the forward selects (regfile / MEM write-back /
//   EXE ALU result) and latches the decoded instruction into EXE. It also
//   detects load-use hazards, inserts a single bubble and stalls IF/ID.
//
// Ports
//   clk, rst              clock (rising edge), synchronous active-high reset
//   valid_id .. ctrl_id   decoded ID-stage instruction fields
//   r*_addr/used/data_id  source operand address, used flag, regfile data
//   r*_forward_id         0 regfile, 1 MEM write-back, 2 EXE ALU, 3 regfile
//   alu_result_exe        current EXE ALU output (forwarding source)
//   wb_data_mem           MEM-stage write-back value (forwarding source)
//   flush                 kill the ID instruction (taken branch/jump)
//   hold                  global freeze
//   *_exe                 latched EXE-stage fields
//   stall_if_id           PC and IF/ID must hold this cycle
//   bubble_count          saturating count of load-use bubbles
// ---------------------------------------------------------------------------
module id_exe_stage #(
   parameter int XLEN   = 32,
   parameter int CTRL_W = 16,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_id,
   input  logic [XLEN-1:0]   pc_id,
   input  logic [XLEN-1:0]   imm_id,
   input  logic [CTRL_W-1:0] ctrl_id,
   input  logic              mem_read_id,
   input  logic [4:0]        rd_addr_id,
   input  logic [4:0]        r1_addr_id,
   input  logic [4:0]        r2_addr_id,
   input  logic              r1_used_id,
   input  logic              r2_used_id,
   input  logic [XLEN-1:0]   r1_data_id,
   input  logic [XLEN-1:0]   r2_data_id,
   input  logic [1:0]        r1_forward_id,
   input  logic [1:0]        r2_forward_id,
   input  logic [XLEN-1:0]   alu_result_exe,
   input  logic [XLEN-1:0]   wb_data_mem,
   input  logic              flush,
   input  logic              hold,
   output logic              valid_exe,
   output logic [XLEN-1:0]   pc_exe,
   output logic [XLEN-1:0]   imm_exe,
   output logic [XLEN-1:0]   r1_data_exe,
   output logic [XLEN-1:0]   r2_data_exe,
   output logic [CTRL_W-1:0] ctrl_exe,
   output logic              mem_read_exe,
   output logic [4:0]        rd_addr_exe,
   output logic              stall_if_id,
   output logic [CNT_W-1:0]  bubble_count
);

   localparam logic [1:0] FWD_MEM = 2'd1;
   localparam logic [1:0] FWD_EXE = 2'd2;

   // Select 3 is reserved and falls through to regfile data.
   function automatic logic [XLEN-1:0] fwd_mux(input logic [1:0]      sel,
                                                input logic [XLEN-1:0] rf,
                                                input logic [XLEN-1:0] mem,
                                                input logic [XLEN-1:0] exe);
      case (sel)
         FWD_MEM: fwd_mux = mem;
         FWD_EXE: fwd_mux = exe;
         default: fwd_mux = rf;
      endcase
   endfunction

   logic [XLEN-1:0] op1, op2;
   logic            hit1, hit2, lu;

   assign op1 = fwd_mux(r1_forward_id, r1_data_id, wb_data_mem, alu_result_exe);
   assign op2 = fwd_mux(r2_forward_id, r2_data_id, wb_data_mem, alu_result_exe);

   // A load in EXE delivers its data only from MEM, one cycle too late for
   // an ID consumer; x0 is never a real destination.
   assign hit1 = r1_used_id && (r1_addr_id == rd_addr_exe);
   assign hit2 = r2_used_id && (r2_addr_id == rd_addr_exe);
   assign lu   = valid_id && valid_exe && mem_read_exe &&
                 (rd_addr_exe != 5'd0) && (hit1 || hit2);

   assign stall_if_id = (lu || hold) && !flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_exe    <= 1'b0;
         ctrl_exe     <= '0;
         mem_read_exe <= 1'b0;
         rd_addr_exe  <= '0;
         pc_exe       <= '0;
         imm_exe      <= '0;
         r1_data_exe  <= '0;
         r2_data_exe  <= '0;
         bubble_count <= '0;
      end else if (flush) begin
         // Bubble: only the fields that make EXE act are cleared, data held.
         valid_exe    <= 1'b0;
         ctrl_exe     <= '0;
         mem_read_exe <= 1'b0;
         rd_addr_exe  <= '0;
      end else if (hold) begin
         // Global freeze: every register keeps its value.
      end else if (lu) begin
         valid_exe    <= 1'b0;
         ctrl_exe     <= '0;
         mem_read_exe <= 1'b0;
         rd_addr_exe  <= '0;
         if (bubble_count != '1)
            bubble_count <= bubble_count + 1'b1;
      end else begin
         valid_exe    <= valid_id;
         ctrl_exe     <= valid_id ? ctrl_id : '0;
         mem_read_exe <= valid_id && mem_read_id;
         rd_addr_exe  <= valid_id ? rd_addr_id : 5'd0;
         pc_exe       <= pc_id;
         imm_exe      <= imm_id;
         r1_data_exe  <= op1;
         r2_data_exe  <= op2;
      end
   end

endmodule
